fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the address of the first fetch after reset.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port npc_valid  input  1  current instruction has committed and npc is valid.
REQ-005 The block SHALL have port npc  input  32  next PC from the execute stage.
REQ-006 The block SHALL have ports mem_req_valid  output  1, mem_req_ready  input  1, mem_req_addr  output  32, forming the instruction-memory request channel.
REQ-007 The block SHALL have ports mem_rsp_valid  input  1, mem_rsp_data  input  32, mem_rsp_err  input  1, forming the instruction-memory response channel.
REQ-008 The block SHALL have ports inst_valid  output  1, inst_ready  input  1, inst  output  32, pc  output  32, forming the decode-side channel.
REQ-009 The block SHALL have port fetch_err  output  1, an access fault accompanying inst; valid only while inst_valid=1.
REQ-010 The block SHALL have port fetch_cnt  output  32, the count of completed decode handshakes.

Function
REQ-011 The block SHALL implement states REQ, WAIT, OUT and EXEC.
REQ-012 In REQ, the block SHALL hold mem_req_valid=1 with mem_req_addr=pc stable until the cycle in which mem_req_ready=1, then go to WAIT.
REQ-013 In WAIT, on mem_rsp_valid=1 the block SHALL register inst=mem_rsp_data and fetch_err=mem_rsp_err, then go to OUT.
REQ-014 mem_rsp_valid SHALL be ignored in REQ, OUT and EXEC; the memory returns data no earlier than one cycle after the request handshake.
REQ-015 In OUT, inst_valid SHALL be 1, and inst, pc and fetch_err SHALL be stable until inst_ready=1.
REQ-016 On the handshake cycle in OUT, the block SHALL go to EXEC and increment fetch_cnt by 1, wrapping from 32'hFFFF_FFFF to 0.
REQ-017 In EXEC, on npc_valid=1 the block SHALL load pc from npc and go to REQ; npc_valid in any other state SHALL be ignored.
REQ-018 inst_valid and mem_req_valid SHALL be driven from registered state only, with no combinational path from any input.
REQ-019 Minimum latency from entering REQ to inst_valid=1 SHALL be 2 cycles when mem_req_ready=1 in REQ and mem_rsp_valid=1 on the first WAIT cycle.

Reset
REQ-020 While rst=0 at a clock edge, the block SHALL set state=REQ, pc=RESET_PC, inst=0, fetch_err=0 and fetch_cnt=0.
REQ-021 Reset SHALL take effect from any state, including mid-request and mid-response; responses arriving after reset release to a request issued before reset SHALL NOT be issued by the memory, and this is a system-level rule.
REQ-022 In the first cycle after reset release, mem_req_valid SHALL be 1 with mem_req_addr=RESET_PC.

Configuration
REQ-023 With FETCH_UNIT_ALIGN_CHK_EN defined, a loaded pc whose bits [1:0] are nonzero SHALL skip REQ and WAIT and go directly to OUT with inst=0, fetch_err=1, and pc equal to the unaligned value.
REQ-024 Without FETCH_UNIT_ALIGN_CHK_EN, the block SHALL load pc from {npc[31:2],2'b00}, perform no alignment check, and never raise fetch_err for alignment.

Structure
REQ-025 A shared package fetch_pkg SHALL hold the state enumeration (REQ, WAIT, OUT, EXEC, 2 bits) and the RESET_PC default constant.
REQ-026 The block SHALL be a single module; no sub-module is required.

Verification
REQ-027 Release reset with mem_req_ready=1 and a 1-cycle response of data 32'h0000_0013 -> mem_req_addr=32'h8000_0000 and, 2 cycles later, inst_valid=1, inst=32'h13, pc=32'h8000_0000.
REQ-028 Hold mem_req_ready=0 for 5 cycles -> mem_req_valid=1 and addr stable for all 5 cycles; exactly one request is accepted.
REQ-029 Hold inst_ready=0 for 4 cycles in OUT, then raise npc_valid=1, npc=32'h8000_0010 during OUT -> npc ignored and outputs stable; after the handshake, npc_valid with 32'h8000_0010 -> next mem_req_addr=32'h8000_0010.
REQ-030 Return a response with mem_rsp_err=1 -> inst_valid=1 with fetch_err=1; fetch_cnt increments on the handshake.
REQ-031 With the macro defined, npc=32'h8000_0006 -> no mem_req_valid and OUT with fetch_err=1, pc=32'h8000_0006; without the macro -> mem_req_addr=32'h8000_0004.
REQ-032 Assert rst=0 during WAIT -> the next cycle has state REQ, fetch_cnt=0, inst_valid=0, and mem_req_addr=32'h8000_0000 after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2,
    EXEC = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for response, hand to decode, wait for commit.
// Optional macro FETCH_UNIT_ALIGN_CHK_EN: unaligned npc raises fetch_err without a memory access.
//
// state | meaning
// REQ   | request at pc presented, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid
// OUT   | instruction held for decode until inst_ready
// EXEC  | instruction executing, waiting for npc_valid
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst;
  logic         r_err;
  logic [31:0]  r_cnt;
  logic         w_npc_misaligned;

`ifdef FETCH_UNIT_ALIGN_CHK_EN
  assign w_npc_misaligned = |npc[1:0];
`else
  assign w_npc_misaligned = 1'b0;
  logic w_unused_npc_lo;
  assign w_unused_npc_lo = ^npc[1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_state <= REQ;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REQ:  if (mem_req_ready) w_state_nxt = WAIT;
      WAIT: if (mem_rsp_valid) w_state_nxt = OUT;
      OUT:  if (inst_ready)    w_state_nxt = EXEC;
      EXEC: if (npc_valid)     w_state_nxt = w_npc_misaligned ? OUT : REQ;
      default:                 w_state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc   <= RESET_PC;
      r_inst <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        WAIT: if (mem_rsp_valid) begin
          r_inst <= mem_rsp_data;
          r_err  <= mem_rsp_err;
        end
        OUT: if (inst_ready) r_cnt <= r_cnt + 32'd1;
        EXEC: if (npc_valid) begin
`ifdef FETCH_UNIT_ALIGN_CHK_EN
          r_pc <= npc;
          // Misaligned target is reported as a fault without touching memory.
          if (w_npc_misaligned) begin
            r_inst <= '0;
            r_err  <= 1'b1;
          end
`else
          r_pc <= {npc[31:2], 2'b00};
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req_valid = (r_state == REQ);
    inst_valid    = (r_state == OUT);
    mem_req_addr  = r_pc;
    pc            = r_pc;
    inst          = r_inst;
    fetch_err     = r_err;
    fetch_cnt     = r_cnt;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; inputs driven and outputs sampled on the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        npc_valid;
  logic [31:0] npc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_req = 0;
  int req_base;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .npc_valid(npc_valid), .npc(npc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
  );

  always @(posedge clk)
    if (rst && mem_req_valid && mem_req_ready) n_req++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; npc_valid = 1'b0; npc = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0; inst_ready = 1'b0;
    step(); step();
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);

    // Release reset, immediate accept, 1-cycle response.
    rst = 1'b1; mem_req_ready = 1'b1;
    chk("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("first_req_addr", mem_req_addr, 32'h8000_0000);
    step();
    mem_req_ready = 1'b0;
    chk("wait_no_req", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0013; mem_rsp_err = 1'b0;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'hFFFF_FFFF;
    chk("lat_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("lat_inst", inst, 32'h0000_0013);
    chk("lat_pc", pc, 32'h8000_0000);
    chk("lat_err", {31'd0, fetch_err}, 32'd0);

    // Decode stall with npc_valid asserted during OUT: must be ignored.
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) begin npc_valid = 1'b1; npc = 32'h8000_0010; end
      step();
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, 32'h0000_0013);
      chk("stall_pc", pc, 32'h8000_0000);
    end
    npc_valid = 1'b0;
    chk("cnt_before_hs", fetch_cnt, 32'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("cnt_after_hs", fetch_cnt, 32'd1);
    chk("exec_no_inst", {31'd0, inst_valid}, 32'd0);
    step();
    chk("exec_hold_no_req", {31'd0, mem_req_valid}, 32'd0);
    npc_valid = 1'b1; npc = 32'h8000_0010;
    step();
    npc_valid = 1'b0;
    chk("npc_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("npc_req_addr", mem_req_addr, 32'h8000_0010);

    // Memory backpressure for 5 cycles, then exactly one accept.
    req_base = n_req;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("bp_addr", mem_req_addr, 32'h8000_0010);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    step();
    chk("one_accept", n_req - req_base, 32'd1);
    mem_req_ready = 1'b0;
    chk("wait_idle", {31'd0, inst_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF; mem_rsp_err = 1'b1;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    chk("err_valid", {31'd0, inst_valid}, 32'd1);
    chk("err_flag", {31'd0, fetch_err}, 32'd1);
    chk("err_inst", inst, 32'hDEAD_BEEF);
    chk("err_pc", pc, 32'h8000_0010);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("err_cnt", fetch_cnt, 32'd2);

    // Unaligned next pc.
    npc_valid = 1'b1; npc = 32'h8000_0006;
    step();
    npc_valid = 1'b0;
`ifdef FETCH_UNIT_ALIGN_CHK_EN
    chk("al_no_req", {31'd0, mem_req_valid}, 32'd0);
    chk("al_valid", {31'd0, inst_valid}, 32'd1);
    chk("al_err", {31'd0, fetch_err}, 32'd1);
    chk("al_pc", pc, 32'h8000_0006);
    chk("al_inst", inst, 32'd0);
`else
    chk("al_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("al_req_addr", mem_req_addr, 32'h8000_0004);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0093;
    step();
    mem_rsp_valid = 1'b0;
    chk("al_inst", inst, 32'h0000_0093);
    chk("al_err", {31'd0, fetch_err}, 32'd0);
    chk("al_pc", pc, 32'h8000_0004);
`endif
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("al_cnt", fetch_cnt, 32'd3);

    // Reset asserted while waiting for a response.
    npc_valid = 1'b1; npc = 32'h8000_0020;
    step();
    npc_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("pre_rst_wait", {31'd0, mem_req_valid}, 32'd0);
    rst = 1'b0;
    step();
    chk("mid_rst_state_req", {31'd0, mem_req_valid}, 32'd1);
    chk("mid_rst_cnt", fetch_cnt, 32'd0);
    chk("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    rst = 1'b1;
    chk("mid_rst_addr", mem_req_addr, 32'h8000_0000);

    // Response strobe while still in REQ must be ignored.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    step();
    mem_rsp_valid = 1'b0;
    chk("req_rsp_ignored_valid", {31'd0, inst_valid}, 32'd0);
    chk("req_rsp_ignored_inst", inst, 32'd0);
    chk("req_still_req", {31'd0, mem_req_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
